mac_pe_systolic: RTL

//  Parametrised multiply-accumulate processing element for 2-D systolic matrix multiply.
//  A flows left->right, B flows top->bottom, each with a 1-cycle register per PE.
//  Two-stage pipeline: stage 1 registers the multiply, stage 2 accumulates.

---
 rtl/mac_pkg.sv | 25 ++
 rtl/mac_mul_stage.sv | 38 +++
 rtl/mac_pe_systolic.sv | 105 ++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared defaults, product extension and saturation limits for the MAC processing element
package mac_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 24;
  localparam int MAX_W      = 64;

  // Widen a pw-bit product to 64 bits, sign-extending when sgn is set
  function automatic logic [63:0] ext_prod(input logic [63:0] p, input int pw, input bit sgn);
    logic [63:0] m;
    m = (64'd1 << pw) - 64'd1;
    return (sgn && p[pw-1]) ? (p | ~m) : (p & m);
  endfunction

  // Largest representable accumulator value for width aw
  function automatic logic [63:0] sat_max(input int aw, input bit sgn);
    return sgn ? (64'd1 << (aw - 1)) - 64'd1 : (64'd1 << aw) - 64'd1;
  endfunction

  // Smallest representable accumulator value for width aw
  function automatic logic [63:0] sat_min(input int aw, input bit sgn);
    return sgn ? ~((64'd1 << (aw - 1)) - 64'd1) : 64'd0;
  endfunction

endpackage

// File: rtl/mac_mul_stage.sv
// mac_mul_stage: stage-1 multiplier with registered product and valid; kill discards the in-flight product
module mac_mul_stage
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  kill,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   prod,
  output logic                  vld
);

  logic signed [2*DATA_W-1:0] s_mul;
  logic        [2*DATA_W-1:0] u_mul;
  logic                       pvld;

  assign s_mul = $signed(a) * $signed(b);
  assign u_mul = a * b;

  // Register the product every cycle; valid follows en_in even during clr so a new pair is not lost
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prod <= '0;
      pvld <= 1'b0;
    end else begin
      prod <= (SIGNED != 0) ? s_mul : u_mul;
      pvld <= en;
    end

  // A product still in flight when clr or drain wins stage 2 is never accumulated
  assign vld = pvld & ~kill;

endmodule

// File: rtl/mac_pe_systolic.sv
// mac_pe_systolic: two-stage MAC processing element for a 2-D systolic array with drain chain.
// Optional build macro MAC_SAT_EN: overflowing accumulates clamp to the accumulator limits instead of wrapping.
module mac_pe_systolic
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_in,
  input  logic              clr,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              drain,
  input  logic [ACC_W-1:0]  drain_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              en_out,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);

  if (ACC_W < 2 * DATA_W || ACC_W >= MAX_W) begin : g_bad_width
    $error("mac_pe_systolic: ACC_W must be >= 2*DATA_W and < 64");
  end

  logic [2*DATA_W-1:0] prod;
  logic                vld;
  logic [63:0]         ext64;
  logic [ACC_W-1:0]    ext;
  logic [ACC_W-1:0]    sum;
  logic [ACC_W-1:0]    nxt;
  logic                carry;
  logic                ov;
  logic                hold;
  logic                upd;

  mac_mul_stage #(
    .DATA_W(DATA_W),
    .SIGNED(SIGNED)
  ) u_mul (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en_in),
    .kill (clr | drain),
    .a    (a_in),
    .b    (b_in),
    .prod (prod),
    .vld  (vld)
  );

  // Forward operands and valid to the east/south neighbours unconditionally
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_out  <= '0;
      b_out  <= '0;
      en_out <= 1'b0;
    end else begin
      a_out  <= a_in;
      b_out  <= b_in;
      en_out <= en_in;
    end

  assign ext64        = ext_prod(64'(prod), 2 * DATA_W, SIGNED != 0);
  assign ext          = ext64[ACC_W-1:0];
  assign {carry, sum} = {1'b0, acc} + {1'b0, ext};
  assign ov           = (SIGNED != 0) ? (acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1])
                                      : carry;

`ifdef MAC_SAT_EN
  logic [63:0] lim;
  logic        sat;

  assign lim  = (SIGNED != 0 && acc[ACC_W-1]) ? sat_min(ACC_W, SIGNED != 0) : sat_max(ACC_W, SIGNED != 0);
  assign nxt  = ov ? lim[ACC_W-1:0] : sum;
  assign hold = sat;

  // Once clamped the accumulator freezes until clr or drain reloads it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sat <= 1'b0;
    else if (clr || drain) sat <= 1'b0;
    else if (vld && ov) sat <= 1'b1;
`else
  assign nxt  = sum;
  assign hold = 1'b0;
`endif

  assign upd = vld & ~hold;

  // Stage 2: clr beats drain beats accumulate; otherwise hold
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (clr) acc <= '0;
    else if (drain) acc <= drain_in;
    else if (upd) acc <= nxt;

  // Sticky overflow, cleared only by clr or reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf <= 1'b0;
    else if (clr) ovf <= 1'b0;
    else if (!drain && vld && ov) ovf <= 1'b1;

endmodule
